// File: rtl/alu_slice_unop.sv
// Slice-serial unary ALU: CPL/NEG/INC/DEC/PASS on a WIDTH-bit operand,
// SLICE bits per cycle LSB first, with Z/N/H/C flags and start/busy/done.
module alu_slice_unop #(
   parameter int WIDTH = 8,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] operand,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             neg,
   output logic             half,
   output logic             carry
);

   localparam int NS = WIDTH / SLICE;
   localparam int KW = (NS > 1) ? $clog2(NS) : 1;

   generate
      if (SLICE < 1 || SLICE > WIDTH || (WIDTH % SLICE) != 0) begin : g_bad_cfg
         $error("alu_slice_unop: WIDTH must be a multiple of SLICE and 1 <= SLICE <= WIDTH");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   localparam logic [2:0] OP_CPL = 3'd0;
   localparam logic [2:0] OP_NEG = 3'd1;
   localparam logic [2:0] OP_INC = 3'd2;
   localparam logic [2:0] OP_DEC = 3'd3;

   state_t                 state;
   logic [2:0]             op_q;
   logic [WIDTH-1:0]       src;
   logic [WIDTH-1:0]       acc;
   logic                   chain;
   logic                   half_s;
   logic [KW-1:0]          k;

   logic [SLICE-1:0]       b;
   logic [SLICE:0]         sum;
   logic                   first;
   logic                   last;
   logic                   cin;
   logic                   cout;
   logic                   sflag;
   logic [WIDTH+SLICE-1:0] cat;
   logic [WIDTH-1:0]       acc_nxt;

   // DEC is b + all-ones with the inverted borrow as carry-in, so slice 0 takes 0.
   // Flags report carry for INC and borrow (inverted adder carry) for NEG/DEC.
   always_comb begin
      b     = src[SLICE-1:0];
      first = (k == '0);
      last  = (k == KW'(NS - 1));
      cin   = first ? (op_q != OP_DEC) : chain;
      sum   = '0;
      case (op_q)
         OP_CPL:  sum = {1'b0, ~b};
         OP_NEG:  sum = {1'b0, ~b} + (SLICE+1)'(cin);
         OP_INC:  sum = {1'b0, b} + (SLICE+1)'(cin);
         OP_DEC:  sum = {1'b0, b} + {1'b0, {SLICE{1'b1}}} + (SLICE+1)'(cin);
         default: sum = {1'b0, b};
      endcase
      cout = sum[SLICE];
      case (op_q)
         OP_INC:         sflag = cout;
         OP_NEG, OP_DEC: sflag = ~cout;
         default:        sflag = 1'b0;
      endcase
      cat     = {sum[SLICE-1:0], acc};
      acc_nxt = cat[WIDTH+SLICE-1:SLICE];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
         zero   <= 1'b0;
         neg    <= 1'b0;
         half   <= 1'b0;
         carry  <= 1'b0;
         k      <= '0;
         op_q   <= '0;
         src    <= '0;
         acc    <= '0;
         chain  <= 1'b0;
         half_s <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               src   <= src >> SLICE;
               acc   <= acc_nxt;
               chain <= cout;
               if (first) half_s <= sflag;
               if (last) begin
                  state  <= FIN;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  result <= acc_nxt;
                  zero   <= (acc_nxt == '0);
                  carry  <= sflag;
                  half   <= first ? sflag : half_s;
                  neg    <= (op_q == OP_CPL) || (op_q == OP_NEG) || (op_q == OP_DEC);
                  k      <= '0;
               end else begin
                  k <= k + 1'b1;
               end
            end
            default: begin
               done <= 1'b0;
               if (start) begin
                  op_q  <= op;
                  src   <= operand;
                  acc   <= '0;
                  k     <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_slice_unop.sv
// Bench for alu_slice_unop: three configurations (8/4, 16/4, 8/8) share one
// stimulus stream; each is tracked by a cycle-level arithmetic model.
module tb_alu_slice_unop;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [15:0] operand;
   logic        armed = 1'b0;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Returns {zero, neg, half, carry, result[15:0]} straight from the arithmetic rules.
   function automatic logic [19:0] model(input int w, input int s, input logic [2:0] o,
                                         input logic [15:0] x);
      logic [31:0] m, sm, xv, s0, r;
      logic        z, n, h, c;
      m  = (32'd1 << w) - 32'd1;
      sm = (32'd1 << s) - 32'd1;
      xv = {16'd0, x} & m;
      s0 = xv & sm;
      n = 1'b0; h = 1'b0; c = 1'b0;
      case (o)
         3'd0: begin r = ~xv;         n = 1'b1; end
         3'd1: begin r = 32'd0 - xv;  n = 1'b1; c = (xv != 0); h = (s0 != 0); end
         3'd2: begin r = xv + 32'd1;  c = (xv == m); h = (s0 == sm); end
         3'd3: begin r = xv - 32'd1;  n = 1'b1; c = (xv == 0); h = (s0 == 0); end
         default: r = xv;
      endcase
      r = r & m;
      z = (r == 0);
      return {z, n, h, c, r[15:0]};
   endfunction

   generate
      for (genvar G = 0; G < 3; G++) begin : g_cfg
         localparam int W  = (G == 1) ? 16 : 8;
         localparam int S  = (G == 2) ? 8 : 4;
         localparam int NS = W / S;

         logic         r_busy, r_done, r_zero, r_neg, r_half, r_carry;
         logic [W-1:0] r_res;
         int           rem = 0;
         logic         exp_done = 1'b0;
         logic [19:0]  pend = '0;
         logic [19:0]  expv = '0;

         alu_slice_unop #(.WIDTH(W), .SLICE(S)) dut (
            .clk    (clk),
            .reset  (reset),
            .start  (start),
            .op     (op),
            .operand(operand[W-1:0]),
            .busy   (r_busy),
            .done   (r_done),
            .result (r_res),
            .zero   (r_zero),
            .neg    (r_neg),
            .half   (r_half),
            .carry  (r_carry)
         );

         // rem counts cycles left in the operation; start is only honoured when it is 0.
         always @(posedge clk) begin
            if (reset) begin
               rem      <= 0;
               exp_done <= 1'b0;
               expv     <= '0;
            end else if (rem > 0) begin
               rem      <= rem - 1;
               exp_done <= (rem == 1);
               if (rem == 1) expv <= pend;
            end else begin
               exp_done <= 1'b0;
               if (start) begin
                  rem  <= NS;
                  pend <= model(W, S, op, operand);
               end
            end
         end

         always @(negedge clk) begin
            if (armed) begin
               chk($sformatf("g%0d busy", G),   32'(r_busy),  32'(rem > 0));
               chk($sformatf("g%0d done", G),   32'(r_done),  32'(exp_done));
               chk($sformatf("g%0d result", G), 32'(r_res),   {16'd0, expv[15:0]});
               chk($sformatf("g%0d zero", G),   32'(r_zero),  32'(expv[19]));
               chk($sformatf("g%0d neg", G),    32'(r_neg),   32'(expv[18]));
               chk($sformatf("g%0d half", G),   32'(r_half),  32'(expv[17]));
               chk($sformatf("g%0d carry", G),  32'(r_carry), 32'(expv[16]));
            end
         end
      end
   endgenerate

   task automatic issue(input logic [2:0] o, input logic [15:0] x);
      @(negedge clk);
      start = 1'b1; op = o; operand = x;
      @(negedge clk);
      start = 1'b0; op = 3'($urandom); operand = 16'($urandom);
   endtask

   task automatic run(input logic [2:0] o, input logic [15:0] x);
      issue(o, x);
      repeat (5) @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; op = '0; operand = '0;
      repeat (2) @(negedge clk);
      armed = 1'b1;
      reset = 1'b0;

      run(3'd0, 16'h005A);
      chk("cpl 5a", 32'(g_cfg[0].r_res), 32'h00A5);
      run(3'd2, 16'h000F);
      chk("inc 0f", 32'(g_cfg[0].r_res), 32'h0010);
      run(3'd2, 16'h00FF);
      chk("inc ff", 32'(g_cfg[0].r_res), 32'h0000);
      chk("inc ff 16b", 32'(g_cfg[1].r_res), 32'h0100);
      run(3'd3, 16'h0000);
      chk("dec 00", 32'(g_cfg[0].r_res), 32'h00FF);
      run(3'd1, 16'h0001);
      chk("neg 01", 32'(g_cfg[0].r_res), 32'h00FF);
      run(3'd1, 16'h0000);
      run(3'd0, 16'h1234);
      chk("cpl 1234 16b", 32'(g_cfg[1].r_res), 32'hEDCB);
      run(3'd4, 16'hC3A5);
      run(3'd6, 16'h8001);

      // start during RUN is ignored; start in the FIN cycle is accepted
      @(negedge clk); start = 1'b1; op = 3'd0; operand = 16'h0000;
      @(negedge clk); start = 1'b1; op = 3'd2; operand = 16'h0033;
      @(negedge clk); start = 1'b0;
      @(negedge clk); start = 1'b1; op = 3'd2; operand = 16'h0033;
      @(negedge clk); start = 1'b0;
      repeat (5) @(negedge clk);
      chk("b2b inc 33", 32'(g_cfg[0].r_res), 32'h0034);

      // reset in the second RUN cycle aborts; a fresh op then completes
      @(negedge clk); start = 1'b1; op = 3'd3; operand = 16'h0010;
      @(negedge clk); start = 1'b0;
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      chk("abort result", 32'(g_cfg[0].r_res), 32'h0000);
      run(3'd3, 16'h0010);
      chk("dec 10", 32'(g_cfg[0].r_res), 32'h000F);

      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         start   = ($urandom_range(0, 2) == 0);
         op      = 3'($urandom);
         operand = 16'($urandom);
         reset   = ($urandom_range(0, 59) == 0);
      end
      @(negedge clk); start = 1'b0; reset = 1'b0;
      repeat (6) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_slice_unop.md
Name: alu_slice_unop

Overview:
- Parametrised, slice-serial unary ALU unit: generalised successor of the fixed 8-bit, two-nibble complement path.
- Processes a WIDTH-bit operand SLICE bits per cycle, LSB slice first, with a carry/borrow chain between slices.
- Supports CPL, NEG, INC, DEC and PASS, with start/busy/done handshake and Z/N/H/C flags.
- Sits beside the main ALU datapath and serves wide (e.g. 16-bit) unary operations without widening the core adder.

Parameters:
- WIDTH, 8: operand/result width in bits.
- SLICE, 4: bits processed per cycle. WIDTH % SLICE == 0 and 1 <= SLICE <= WIDTH are required, otherwise elaboration fails. NS = WIDTH/SLICE.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when the unit is not busy.
- op  in  3  0=CPL, 1=NEG, 2=INC, 3=DEC, 4=PASS, 5..7 treated as PASS.
- operand  in  WIDTH  source value; latched with start.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- result  out  WIDTH  registered result; held until the next completion.
- zero  out  1  result == 0.
- neg  out  1  N flag: 1 for CPL, NEG, DEC; else 0.
- half  out  1  carry/borrow out of slice 0.
- carry  out  1  carry/borrow out of the top slice.

Behaviour:
- Reset (synchronous, active-high): state IDLE; busy, done, result, zero, neg, half, carry all 0; slice counter 0. Reset asserted mid-operation aborts it: no done pulse, and outputs go to 0 on that edge.
- States:
  - IDLE: busy=0.
  - RUN: busy=1; slice counter k runs 0..NS-1.
  - FIN: done=1, busy=0; lasts exactly one cycle, then IDLE.
- Accept: start=1 at edge t while in IDLE or FIN latches op and operand and enters RUN with k=0. Start during RUN is ignored.
- Latency: slice k is computed in cycle t+1+k. The final slice registers at edge t+NS. FIN (done=1) and the updated result and flags are visible in the cycle after edge t+NS, i.e. NS+1 cycles after the accept edge.
- Back-to-back: start in the FIN cycle goes straight to RUN; done drops next cycle.
- Slice arithmetic, with b = latched operand slice:
  - CPL: r = ~b, chain unused.
  - NEG: r = ~b + cin, with cin(slice0) = 1.
  - INC: r = b + cin, with cin(slice0) = 1.
  - DEC: r = b + all-ones + ~bin, with borrow into slice0 = 1.
  - PASS: r = b.
- The chain bit is registered between slices and never leaks between operations.
- Flags:
  - CPL, PASS: carry = 0, half = 0.
  - INC: carry = (operand == all ones); half = (slice0 == all ones).
  - DEC: carry = (operand == 0); half = (slice0 == 0).
  - NEG: carry = (operand != 0); half = (slice0 != 0).
  - zero = (result == 0) for every op.
- SLICE == WIDTH: half equals carry.
- Outputs update only at the transition into FIN. Partial results are never visible on result, and result/flags remain stable through RUN.
- Operand or op changes after the accept edge have no effect.

Test Plan (WIDTH=8, SLICE=4 unless stated):
- CPL 0x5A, start at edge t -> busy cycles t+1..t+2, done only at t+3; result 0xA5, zero=0, carry=0, half=0, neg=1.
- INC 0x0F -> 0x10, half=1, carry=0. INC 0xFF -> 0x00, zero=1, half=1, carry=1, neg=0.
- DEC 0x00 -> 0xFF, carry=1, half=1, neg=1. NEG 0x01 -> 0xFF, carry=1, half=1. NEG 0x00 -> 0x00, zero=1, carry=0.
- Start CPL 0x00, then start INC 0x33 during RUN (ignored); start INC 0x33 in the FIN cycle -> first result 0xFF, then 0x34 with a done pulse 3 cycles later and no extra done.
- Reset at the second RUN cycle of DEC 0x10 -> next cycle all outputs 0, no done; a new start afterwards completes normally (0x0F).
- WIDTH=16, SLICE=4: CPL 0x1234 -> 0xEDCB with done 5 cycles after accept; INC 0x00FF -> 0x0100, half=1, carry=0.
